branch_resolve_ctrl: RTL
========================

Name: branch_resolve_ctrl

Overview:
- Sequences conditional-branch resolution for the WISC pipeline.
- Accepts a decoded branch (3-bit condition code plus target PC) from decode and holds the front end stalled until execute publishes ALU flags.
- Evaluates the condition, then issues a one-cycle PC redirect followed by a parameterised IF/ID flush.
- Keeps saturating branch and taken counters for performance reads.

Parameters:
- FLUSH_CYCLES, 2: cycles flush is asserted per taken branch, including the redirect cycle; legal range 1..15.
- MAX_WAIT, 8: maximum cycles spent in RESOLVE waiting for flags before timeout; legal range 1..255.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- br_valid  in  1  decode presents a branch
- br_ready  out  1  controller can accept a branch
- br_code  in  3  condition code: 000 none, 001 carry, 010 eq, 011 ge, 100 lt, 101 ne, 110 le, 111 always
- br_target  in  16  target PC
- flags_valid  in  1  execute flags are valid this cycle
- sf, zf, of, cf  in  1 each  sign, zero, overflow and carry flags
- stall  out  1  hold PC and IF/ID
- redirect  out  1  one-cycle pulse: load redirect_pc
- redirect_pc  out  16  latched target
- flush  out  1  squash IF/ID
- timeout  out  1  one-cycle pulse on flag wait expiry
- br_cnt  out  CNT_W  branches accepted (saturating)
- taken_cnt  out  CNT_W  branches taken (saturating)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE; br_ready=1; all other outputs 0; redirect_pc=0; counters=0.
- Reset mid-operation: next state is IDLE. Latched code and target are discarded; no redirect is issued.
- Output timing: all outputs are registered or decoded purely from state (Moore). No combinational path from any input to any output.
- Handshake: accept occurs when br_valid & br_ready. br_ready=1 only in IDLE. Inputs present while busy are ignored, not queued.
- Accept with br_code=000: no-op. No state change, counter not incremented.
- Accept with any nonzero code: latch br_code and br_target; increment br_cnt.
- Flag evaluation (branch_cond_eval):
  - 001: cf
  - 010: zf
  - 011: !sf
  - 100: sf
  - 101: !zf
  - 110: sf|zf
  - 111: 1
  - of is an input only; no code uses it.
- States:
  - IDLE: on accept, code 111 goes to REDIRECT; other nonzero codes go to RESOLVE with the wait counter cleared.
  - RESOLVE: stall=1. If flags_valid, flags are sampled that cycle: taken goes to REDIRECT, not-taken goes to IDLE. Otherwise the wait counter increments. When the counter reaches MAX_WAIT without flags_valid: pulse timeout next cycle, treat as not-taken, go to IDLE. flags_valid on the same cycle as expiry wins over timeout.
  - REDIRECT: exactly one cycle. redirect=1, flush=1, stall=1, redirect_pc=latched target. Increment taken_cnt. If FLUSH_CYCLES=1 go to IDLE, else go to FLUSH with the flush counter set to FLUSH_CYCLES-1.
  - FLUSH: flush=1, stall=1; decrement the counter; go to IDLE when it reaches 1.
- Latency:
  - Code 111 accepted in cycle N: redirect in N+1; br_ready returns in N+1+FLUSH_CYCLES.
  - Conditional branch with flags_valid in cycle M: redirect in M+1. If not taken, br_ready returns in M+1.
- Counters: saturate at all-ones and never wrap. They reset only on rst.

Decomposition:
- Shared package wisc_br_pkg:
  - 3-bit condition-code constants: BR_NONE, BR_CO, BR_EQ, BR_GE, BR_LT, BR_NE, BR_LE, BR_ALW.
  - 2-bit state encoding: IDLE=00, RESOLVE=01, REDIRECT=10, FLUSH=11.
- One combinational sub-module, branch_cond_eval: inputs code, sf, zf, of, cf; output taken. Implements the evaluation table above, with 000 giving 0.

Test Plan:
- rst, then br_valid with code 111 and target 0x0040 at cycle 1 -> redirect=1 with redirect_pc=0x0040 at cycle 2; flush high for cycles 2-3; br_ready=1 at cycle 4; br_cnt=1, taken_cnt=1.
- Code 010, flags_valid and zf=1 two cycles after accept -> stall held 3 cycles, then a single redirect pulse. Repeat with zf=0 -> no redirect, br_ready=1 the cycle after flags_valid, taken_cnt unchanged.
- Sweep all codes 001-110 against all 16 sf/zf/of/cf combinations -> redirect matches the evaluation table; of never affects the result.
- Code 100 with no flags_valid for MAX_WAIT=8 cycles -> one timeout pulse, no redirect, back to IDLE. Then a case with flags_valid on the expiry cycle -> normal resolution, timeout=0.
- rst asserted during RESOLVE and again during FLUSH -> next cycle all outputs are at reset values and no redirect is issued; a br_valid presented while in FLUSH is not accepted and br_cnt does not change.
- Force br_cnt to 0xFFFE, then issue 3 branches -> br_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared encodings for WISC branch resolution: condition codes and controller states.
package wisc_br_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_CO   = 3'b001;
    localparam logic [2:0] BR_EQ   = 3'b010;
    localparam logic [2:0] BR_GE   = 3'b011;
    localparam logic [2:0] BR_LT   = 3'b100;
    localparam logic [2:0] BR_NE   = 3'b101;
    localparam logic [2:0] BR_LE   = 3'b110;
    localparam logic [2:0] BR_ALW  = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RESOLVE  = 2'b01,
        REDIRECT = 2'b10,
        FLUSH    = 2'b11
    } br_state_t;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Decode-to-controller branch handshake: valid/ready plus condition code and target PC.
interface branch_resolve_ctrl_if;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_code;
    logic [15:0] br_target;

    modport master (output br_valid, br_code, br_target, input br_ready);
    modport slave  (input br_valid, br_code, br_target, output br_ready);
endinterface

// File: rtl/branch_resolve_ctrl_cond_eval.sv
// Maps a branch condition code and ALU flags to a taken decision.
module branch_cond_eval
    import wisc_br_pkg::*;
(
    input  logic [2:0] code,
    input  logic       sf,
    input  logic       zf,
    input  logic       of,
    input  logic       cf,
    output logic       taken
);

    // Overflow is carried on the flag bus but no condition code consumes it.
    logic unused_of;
    assign unused_of = of;

    always_comb begin
        taken = 1'b0;
        case (code)
            BR_CO:   taken = cf;
            BR_EQ:   taken = zf;
            BR_GE:   taken = !sf;
            BR_LT:   taken = sf;
            BR_NE:   taken = !zf;
            BR_LE:   taken = sf | zf;
            BR_ALW:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: stalls the front end until flags arrive, then redirects and flushes IF/ID.
module branch_resolve_ctrl
    import wisc_br_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MAX_WAIT     = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_ctrl_if.slave  dec,
    input  logic                  flags_valid,
    input  logic                  sf,
    input  logic                  zf,
    input  logic                  of,
    input  logic                  cf,
    output logic                  stall,
    output logic                  redirect,
    output logic [15:0]           redirect_pc,
    output logic                  flush,
    output logic                  timeout,
    output logic [CNT_W-1:0]      br_cnt,
    output logic [CNT_W-1:0]      taken_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       WAIT_LAST = 8'(MAX_WAIT - 1);
    localparam logic [3:0]       FLUSH_REM = 4'(FLUSH_CYCLES - 1);

    br_state_t        state, state_nxt;
    logic [2:0]       code_q;
    logic [15:0]      target_q;
    logic [7:0]       wait_cnt;
    logic [3:0]       flush_cnt;
    logic             timeout_q;
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] taken_cnt_q;
    logic             ready_c;
    logic             accept;
    logic             cond_taken;
    logic             wait_expired;

    branch_cond_eval u_cond_eval (
        .code  (code_q),
        .sf    (sf),
        .zf    (zf),
        .of    (of),
        .cf    (cf),
        .taken (cond_taken)
    );

    // A code of 000 is a no-op: it completes the handshake but never leaves IDLE.
    assign accept       = dec.br_valid && (state == IDLE) && (dec.br_code != BR_NONE);
    assign wait_expired = (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        stall     = 1'b0;
        redirect  = 1'b0;
        flush     = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (accept) begin
                    state_nxt = (dec.br_code == BR_ALW) ? REDIRECT : RESOLVE;
                end
            end
            RESOLVE: begin
                stall = 1'b1;
                if (flags_valid) begin
                    state_nxt = cond_taken ? REDIRECT : IDLE;
                end else if (wait_expired) begin
                    state_nxt = IDLE;
                end
            end
            REDIRECT: begin
                stall     = 1'b1;
                redirect  = 1'b1;
                flush     = 1'b1;
                state_nxt = (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
            end
            FLUSH: begin
                stall = 1'b1;
                flush = 1'b1;
                if (flush_cnt == 4'd1) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            code_q      <= BR_NONE;
            target_q    <= '0;
            wait_cnt    <= '0;
            flush_cnt   <= '0;
            timeout_q   <= 1'b0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            state     <= state_nxt;
            timeout_q <= (state == RESOLVE) && !flags_valid && wait_expired;

            if (accept) begin
                code_q   <= dec.br_code;
                target_q <= dec.br_target;
                wait_cnt <= '0;
                if (br_cnt_q != '1) begin
                    br_cnt_q <= br_cnt_q + CNT_ONE;
                end
            end else if ((state == RESOLVE) && !flags_valid) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (state == REDIRECT) begin
                flush_cnt <= FLUSH_REM;
                if (taken_cnt_q != '1) begin
                    taken_cnt_q <= taken_cnt_q + CNT_ONE;
                end
            end else if (state == FLUSH) begin
                flush_cnt <= flush_cnt - 4'd1;
            end
        end
    end

    assign dec.br_ready = ready_c;
    assign redirect_pc  = target_q;
    assign timeout      = timeout_q;
    assign br_cnt       = br_cnt_q;
    assign taken_cnt    = taken_cnt_q;

endmodule
